// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory port arbiter: FSM states, the latched
// operation record and the default port geometry.
package dmem_arb_pkg;

  localparam int DEF_NUM_CORES = 2;
  localparam int DEF_ADDR_W    = 10;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_ID_W      = $clog2(DEF_NUM_CORES);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    DONE
  } arb_state_t;

  // Operation record at the default geometry; the top keeps a
  // parameter-sized record with the same field order.
  typedef struct packed {
    logic [DEF_ID_W-1:0]   id;
    logic                  we;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } arb_op_t;

endpackage

// File: rtl/dmem_port_arbiter_rr_arbiter.sv
// Round-robin pointer plus combinational one-hot winner search starting at
// the pointer; the pointer moves past the last owner on i_update.
module rr_arbiter
  import dmem_arb_pkg::*;
#(
  parameter  int NUM_CORES = DEF_NUM_CORES,
  localparam int ID_W      = $clog2(NUM_CORES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_CORES-1:0] i_req,
  input  logic                 i_update,
  input  logic [ID_W-1:0]      i_last_id,
  output logic [NUM_CORES-1:0] o_gnt,
  output logic [ID_W-1:0]      o_gnt_id,
  output logic                 o_any
);

  logic [ID_W-1:0] r_ptr;
  logic [ID_W:0]   w_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (i_update) begin
      r_ptr <= (i_last_id == ID_W'(NUM_CORES - 1)) ? '0 : i_last_id + 1'b1;
    end
  end

  // One spare bit in w_idx so ptr+i can exceed NUM_CORES-1 before wrapping.
  always_comb begin
    o_gnt    = '0;
    o_gnt_id = '0;
    o_any    = 1'b0;
    w_idx    = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      w_idx = {1'b0, r_ptr} + (ID_W+1)'(i);
      if (w_idx >= (ID_W+1)'(NUM_CORES)) begin
        w_idx = w_idx - (ID_W+1)'(NUM_CORES);
      end
      if (!o_any && i_req[w_idx[ID_W-1:0]]) begin
        o_gnt[w_idx[ID_W-1:0]] = 1'b1;
        o_gnt_id               = w_idx[ID_W-1:0];
        o_any                  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one data-memory port among NUM_CORES L1 controllers, round-robin.
// Optional per-core grant/wait counters when DMEM_ARB_STATS_EN is defined.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int NUM_CORES = DEF_NUM_CORES,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int RD_LAT    = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CORES-1:0]          req,
  input  logic [NUM_CORES-1:0]          req_we,
  input  logic [NUM_CORES*ADDR_W-1:0]   req_addr,
  input  logic [NUM_CORES*DATA_W-1:0]   req_wdata,
  output logic [NUM_CORES-1:0]          gnt,
  output logic [NUM_CORES-1:0]          done,
  output logic [DATA_W-1:0]             rdata,
  output logic                          dmem_rd_en,
  output logic                          dmem_wr_en,
  output logic [ADDR_W-1:0]             dmem_address,
  output logic [DATA_W-1:0]             data_to_dmem,
  input  logic [DATA_W-1:0]             data_from_dmem
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [NUM_CORES*32-1:0]       grant_cnt,
  output logic [NUM_CORES*32-1:0]       wait_cnt
`endif
);

  localparam int ID_W  = $clog2(NUM_CORES);
  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } op_t;

  arb_state_t           r_state;
  arb_state_t           w_next;
  op_t                  r_op;
  op_t                  w_op_in;
  logic [CNT_W-1:0]     r_cnt;
  logic [DATA_W-1:0]    r_rdata;
  logic [NUM_CORES-1:0] w_win;
  logic [ID_W-1:0]      w_win_id;
  logic                 w_any;
  logic                 w_update;

  rr_arbiter #(.NUM_CORES(NUM_CORES)) u_rr (
    .clk       (clk),
    .reset     (reset),
    .i_req     (req),
    .i_update  (w_update),
    .i_last_id (r_op.id),
    .o_gnt     (w_win),
    .o_gnt_id  (w_win_id),
    .o_any     (w_any)
  );

  always_comb begin
    w_op_in.id    = w_win_id;
    w_op_in.we    = req_we[w_win_id];
    w_op_in.addr  = req_addr[w_win_id*ADDR_W +: ADDR_W];
    w_op_in.wdata = req_wdata[w_win_id*DATA_W +: DATA_W];
  end

  // Operand registers are cleared too, so the port idles at zero after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_op    <= '0;
      r_cnt   <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE:   if (w_any) r_op <= w_op_in;
        ACCESS: r_cnt <= CNT_W'(RD_LAT - 1);
        WAIT: begin
          if (r_cnt == '0) r_rdata <= data_from_dmem;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next     = r_state;
    gnt        = '0;
    done       = '0;
    dmem_rd_en = 1'b0;
    dmem_wr_en = 1'b0;
    w_update   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          gnt    = w_win;
          w_next = ACCESS;
        end
      end
      ACCESS: begin
        dmem_wr_en = r_op.we;
        dmem_rd_en = !r_op.we;
        w_next     = r_op.we ? DONE : WAIT;
      end
      WAIT: begin
        if (r_cnt == '0) w_next = DONE;
      end
      DONE: begin
        done[r_op.id] = 1'b1;
        w_update      = 1'b1;
        w_next        = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign dmem_address = r_op.addr;
  assign data_to_dmem = r_op.wdata;
  assign rdata        = r_rdata;

`ifdef DMEM_ARB_STATS_EN
  // A core that owns the port is not counted as waiting even with req high.
  for (genvar g = 0; g < NUM_CORES; g++) begin : g_stats
    logic [31:0] r_gcnt;
    logic [31:0] r_wcnt;
    logic        w_owned;
    assign w_owned = (r_state != IDLE) && (r_op.id == ID_W'(g));
    always_ff @(posedge clk) begin
      if (reset) begin
        r_gcnt <= '0;
        r_wcnt <= '0;
      end else begin
        if (gnt[g] && (r_gcnt != '1)) r_gcnt <= r_gcnt + 1'b1;
        if (req[g] && !gnt[g] && !w_owned && (r_wcnt != '1)) r_wcnt <= r_wcnt + 1'b1;
      end
    end
    assign grant_cnt[g*32 +: 32] = r_gcnt;
    assign wait_cnt[g*32 +: 32]  = r_wcnt;
  end
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomized bench for dmem_port_arbiter: requester agents, a dmem model with
// RD_LAT read pipeline, and a transaction-level reference predicting each cycle.
module tb_dmem_port_arbiter;

  localparam int N      = 2;
  localparam int AW     = 10;
  localparam int DW     = 32;
  localparam int RD_LAT = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req, req_we;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_wdata;
  logic [N-1:0]      gnt, done;
  logic [DW-1:0]     rdata;
  logic              dmem_rd_en, dmem_wr_en;
  logic [AW-1:0]     dmem_address;
  logic [DW-1:0]     data_to_dmem;
  logic [DW-1:0]     data_from_dmem;
`ifdef DMEM_ARB_STATS_EN
  logic [N*32-1:0]   grant_cnt, wait_cnt;
`endif

  always #5 clk = ~clk;

  dmem_port_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT)) dut (
    .clk            (clk),
    .reset          (reset),
    .req            (req),
    .req_we         (req_we),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .gnt            (gnt),
    .done           (done),
    .rdata          (rdata),
    .dmem_rd_en     (dmem_rd_en),
    .dmem_wr_en     (dmem_wr_en),
    .dmem_address   (dmem_address),
    .data_to_dmem   (data_to_dmem),
    .data_from_dmem (data_from_dmem)
`ifdef DMEM_ARB_STATS_EN
    ,
    .grant_cnt      (grant_cnt),
    .wait_cnt       (wait_cnt)
`endif
  );

  int cyc = 0;

  function automatic logic [DW-1:0] fill(input logic [AW-1:0] a);
    return (a == AW'(4)) ? 32'hDEADBEEF : (32'hA5A50000 | DW'(a));
  endfunction

  // dmem: unwritten words read back as fill(addr); data valid RD_LAT cycles after rd_en
  logic [DW-1:0] mem [1024];
  bit            written [1024];
  logic [AW-1:0] rd_pipe [RD_LAT];
  bit            rd_vld [RD_LAT];

  always @(posedge clk) begin
    if (dmem_wr_en === 1'b1) begin
      mem[dmem_address]     <= data_to_dmem;
      written[dmem_address] <= 1'b1;
    end
    for (int i = RD_LAT - 1; i > 0; i--) begin
      rd_pipe[i] <= rd_pipe[i-1];
      rd_vld[i]  <= rd_vld[i-1];
    end
    rd_pipe[0] <= dmem_address;
    rd_vld[0]  <= (dmem_rd_en === 1'b1);
  end

  always_comb begin
    if (rd_vld[RD_LAT-1])
      data_from_dmem = written[rd_pipe[RD_LAT-1]] ? mem[rd_pipe[RD_LAT-1]] : fill(rd_pipe[RD_LAT-1]);
    else
      data_from_dmem = 32'hBAD0BAD0 ^ DW'(cyc);
  end

  // requester agents
  typedef enum int {A_IDLE, A_REQ, A_OWN} ag_t;
  ag_t           ag [N];
  bit            hold [N];
  bit            a_we [N];
  logic [AW-1:0] a_addr [N];
  logic [DW-1:0] a_wdata [N];
  int            p_new  = 0;
  int            p_drop = 0;
  logic [N-1:0]  p_mask = '0;

  // reference model state
  logic [DW-1:0] ref_mem [1024];
  bit            m_busy  = 0;
  bit            m_fresh = 1;
  bit            m_we;
  int            m_owner = 0;
  int            m_ptr   = 0;
  int            m_gcyc  = 0;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata = '0;
  int            m_gcnt [N];
  int            m_wcnt [N];

  int checks = 0;
  int errors = 0;
  int gnt_cyc, done_cyc, wr_strobes;
  int glog [$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic issue(input int c, input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    ag[c] = A_REQ; a_we[c] = we; a_addr[c] = addr; a_wdata[c] = wd; hold[c] = 1'b1;
  endtask

  function automatic bit any_active();
    for (int i = 0; i < N; i++) if (ag[i] != A_IDLE) return 1'b1;
    return 1'b0;
  endfunction

  task automatic step(input bit rst);
    logic [N-1:0] exp_gnt, exp_done;
    bit exp_rd, exp_wr, was_busy;
    int win, owner0, slot;
    @(negedge clk);
    cyc++;
    reset = rst;
    for (int i = 0; i < N; i++) begin
      req[i]                = (ag[i] == A_REQ) || (ag[i] == A_OWN && hold[i]);
      req_we[i]             = a_we[i];
      req_addr[i*AW +: AW]  = a_addr[i];
      req_wdata[i*DW +: DW] = a_wdata[i];
    end
    #1;
    exp_gnt = '0; exp_done = '0; exp_rd = 0; exp_wr = 0;
    was_busy = m_busy; owner0 = m_owner; win = -1;
`ifdef DMEM_ARB_STATS_EN
    for (int i = 0; i < N; i++) begin
      chk("grant_cnt", grant_cnt[i*32 +: 32], m_gcnt[i]);
      chk("wait_cnt", wait_cnt[i*32 +: 32], m_wcnt[i]);
    end
`endif
    if (m_busy) begin
      if (cyc == m_gcyc + 1) begin exp_wr = m_we; exp_rd = !m_we; end
      if (cyc == m_gcyc + (m_we ? 2 : 2 + RD_LAT)) begin
        exp_done[m_owner] = 1'b1;
        if (m_we) ref_mem[m_addr] = m_wdata;
        else      m_rdata = ref_mem[m_addr];
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        slot = (m_ptr + k) % N;
        if (win < 0 && ag[slot] == A_REQ) win = slot;
      end
    end
    if (win >= 0) exp_gnt[win] = 1'b1;
    chk("gnt", gnt, exp_gnt);
    chk("done", done, exp_done);
    chk("rd_en", dmem_rd_en, exp_rd);
    chk("wr_en", dmem_wr_en, exp_wr);
    chk("rdata", rdata, m_rdata);
    chk("excl", dmem_rd_en & dmem_wr_en, 0);
    if (exp_rd || exp_wr) chk("addr", dmem_address, m_addr);
    if (exp_wr) chk("wdata", data_to_dmem, m_wdata);
    if (m_fresh) begin
      chk("addr_rst", dmem_address, 0);
      chk("wdata_rst", data_to_dmem, 0);
    end
    if (gnt != '0) begin gnt_cyc = cyc; glog.push_back(gnt == 2'b01 ? 0 : (gnt == 2'b10 ? 1 : 9)); end
    if (done != '0) done_cyc = cyc;
    if (dmem_wr_en === 1'b1) wr_strobes++;
    for (int i = 0; i < N; i++) begin
      if (exp_gnt[i]) m_gcnt[i]++;
      if (req[i] && !exp_gnt[i] && !(was_busy && owner0 == i)) m_wcnt[i]++;
    end
    if (exp_done != '0) begin
      ag[m_owner] = A_IDLE; m_busy = 0; m_ptr = (m_owner + 1) % N;
    end
    if (win >= 0) begin
      m_busy = 1; m_owner = win; m_gcyc = cyc; m_we = a_we[win];
      m_addr = a_addr[win]; m_wdata = a_wdata[win]; m_fresh = 0;
      ag[win] = A_OWN;
      hold[win] = (p_drop == 0) || ($urandom_range(0, 99) >= p_drop);
    end
    if (rst) begin
      m_busy = 0; m_ptr = 0; m_rdata = '0; m_fresh = 1;
      for (int i = 0; i < N; i++) begin ag[i] = A_IDLE; m_gcnt[i] = 0; m_wcnt[i] = 0; end
    end else begin
      for (int i = 0; i < N; i++)
        if (ag[i] == A_IDLE && p_mask[i] && p_new > 0 && $urandom_range(0, 99) < p_new)
          issue(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom);
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int k = 0;
    p_new = 0;
    while ((m_busy || any_active()) && k < budget) begin step(0); k++; end
    chk(tag, m_busy || any_active(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 1024; a++) ref_mem[a] = fill(AW'(a));
    for (int i = 0; i < N; i++) begin
      ag[i] = A_IDLE; hold[i] = 1; a_we[i] = 0; a_addr[i] = '0; a_wdata[i] = '0;
      m_gcnt[i] = 0; m_wcnt[i] = 0;
    end
    reset = 1'b1; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);

    // reset state: everything quiet and zero
    step(0);
    step(0);

    // single read of a preloaded word
    issue(0, 0, 10'h004, '0);
    drain("rd_timeout", 20);
    chk("rd_lat", done_cyc - gnt_cyc, 2 + RD_LAT);
    chk("rd_data", rdata, 32'hDEADBEEF);

    // single write: one strobe cycle, done two cycles after gnt
    wr_strobes = 0;
    issue(1, 1, 10'h3FF, 32'h12345678);
    drain("wr_timeout", 20);
    chk("wr_lat", done_cyc - gnt_cyc, 2);
    chk("wr_strobes", wr_strobes, 1);

    // contention: both cores requesting continuously
    glog.delete();
    p_mask = 2'b11; p_drop = 0; p_new = 100;
    issue(0, 0, 10'h004, '0);
    issue(1, 1, 10'h005, 32'hCAFEF00D);
    for (int k = 0; k < 60 && glog.size() < 4; k++) step(0);
    drain("cont_timeout", 40);
    chk("cont_count", glog.size() >= 4, 1);
    if (glog.size() >= 4)
      for (int k = 0; k < 4; k++) chk("cont_order", glog[k], k % 2);

    // back-to-back from core0 alone, mixed reads and writes
    glog.delete();
    p_mask = 2'b01; p_new = 100;
    issue(0, 0, 10'h005, '0);
    repeat (40) step(0);
    drain("b2b_timeout", 40);
    chk("b2b_count", glog.size() >= 6, 1);
    foreach (glog[k]) chk("b2b_owner", glog[k], 0);

    // randomized traffic with early req drops after gnt
    p_mask = 2'b11; p_new = 40; p_drop = 30;
    repeat (1500) step(0);
    drain("rand_timeout", 40);
    p_drop = 0;

    // reset during WAIT, after a core0 write has moved the pointer to core1
    issue(0, 1, 10'h007, 32'h0BADCAFE);
    drain("pre_timeout", 20);
    issue(0, 0, 10'h007, '0);
    for (int k = 0; k < 5 && !(m_busy && cyc == m_gcyc + 1); k++) step(0);
    chk("rst_setup", m_busy && cyc == m_gcyc + 1, 1);
    step(1);
    step(0);
    chk("rst_rdata", rdata, 0);
    issue(0, 0, 10'h004, '0);
    issue(1, 0, 10'h005, '0);
    step(0);
    chk("rst_ptr", gnt, 2'b01);
    drain("post_timeout", 40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
